// File: rtl/bht_access_ctrl.sv
// bht_access_ctrl: BHT port owner -- lookup/update arbitration, forwarded RMW counter updates, timed clear sweep.
// Optional BHT_ACCESS_STATS_EN builds upd_cnt/stall_cnt counters; otherwise those ports are tied to 0.
module bht_access_ctrl #(
  parameter int unsigned IDX_W    = 10,
  parameter logic [1:0]  INIT_VAL = 2'b01,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_req,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_rvalid,
  output logic             lk_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             busy,
  output logic [IDX_W-1:0] ram_raddr,
  input  logic [1:0]       ram_rdata,
  output logic             ram_we,
  output logic [IDX_W-1:0] ram_waddr,
  output logic [1:0]       ram_wdata,
  output logic [31:0]      upd_cnt,
  output logic [31:0]      stall_cnt
);
  localparam int unsigned PW = $clog2(QDEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t           state_q;
  logic [IDX_W-1:0] sweep_q, rmw_idx_q;
  logic [IDX_W-1:0] q_idx [QDEPTH];
  logic             q_tkn [QDEPTH];
  logic [PW-1:0]    wp_q, rp_q;
  logic [PW:0]      cnt_q;
  logic             rmw_v_q, rmw_tkn_q, lk_rvalid_q, lk_clr_q, fwd_hit_q;
  logic [1:0]       fwd_val_q, op, new_val;
  logic             run, empty, full, push, pop;
  always_comb begin
    run       = state_q == RUN;
    empty     = cnt_q == '0;
    full      = cnt_q == (PW+1)'(QDEPTH);
    upd_ready = run && !full;
    busy      = !run;
    push      = upd_valid && upd_ready;
    pop       = run && !lk_valid && !empty;
    ram_raddr = !run ? '0 : lk_valid ? lk_idx : pop ? q_idx[rp_q] : '0;
    op        = fwd_hit_q ? fwd_val_q : ram_rdata;
    new_val   = rmw_tkn_q ? (op == 2'b11 ? op : op + 2'b01) : (op == 2'b00 ? op : op - 2'b01);
    // rst gates the write port so nothing is written while reset is held, even though reset state is CLEAR
    ram_we    = rst && (!run || rmw_v_q);
    ram_waddr = !ram_we ? '0 : run ? rmw_idx_q : sweep_q;
    ram_wdata = !ram_we ? '0 : run ? new_val : INIT_VAL;
    lk_rvalid = lk_rvalid_q;
    lk_taken  = lk_rvalid_q && (lk_clr_q ? INIT_VAL[1] : op[1]);
  end
  always_ff @(posedge clk)
    if (push) begin
      q_idx[wp_q] <= upd_idx;
      q_tkn[wp_q] <= upd_taken;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= CLEAR;
      sweep_q     <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      rmw_v_q     <= 1'b0;
      rmw_tkn_q   <= 1'b0;
      rmw_idx_q   <= '0;
      lk_rvalid_q <= 1'b0;
      lk_clr_q    <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_val_q   <= '0;
    end else begin
      lk_rvalid_q <= lk_valid;
      lk_clr_q    <= !run;
      // RAM returns pre-write data on a same-cycle collision, so capture the written value
      fwd_hit_q   <= run && ram_we && (lk_valid || pop) && ram_raddr == ram_waddr;
      fwd_val_q   <= ram_wdata;
      rmw_v_q     <= pop && !flush_req;
      rmw_tkn_q   <= q_tkn[rp_q];
      rmw_idx_q   <= ram_raddr;
      if (flush_req) begin
        state_q <= CLEAR;
        sweep_q <= '0;
        wp_q    <= '0;
        rp_q    <= '0;
        cnt_q   <= '0;
      end else if (!run) begin
        sweep_q <= sweep_q + 1'b1;
        if (&sweep_q) state_q <= RUN;
      end else begin
        wp_q  <= wp_q + PW'(push);
        rp_q  <= rp_q + PW'(pop);
        cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
`ifdef BHT_ACCESS_STATS_EN
  logic [31:0] upd_cnt_q, stall_cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      upd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (flush_req) begin
      upd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      upd_cnt_q   <= upd_cnt_q + 32'(run && rmw_v_q);
      stall_cnt_q <= stall_cnt_q + 32'(upd_valid && !upd_ready);
    end
  assign upd_cnt   = upd_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign upd_cnt   = '0;
  assign stall_cnt = '0;
`endif
endmodule
